// File: rtl/button_debounce_bank.sv
// ---------------------------------------------------------------------------
// button_debounce_bank
//
// Conditions the raw push-button pins before they reach the board control FSM.
// Each channel runs independently through the same chain:
//   pin -> 2-FF synchroniser -> debounce counter -> clean level (btn_state)
// The chain also produces registered single-cycle press/release pulses.
// Channels selected in REPEAT_MASK add auto-repeat press pulses while the
// button stays held. For example, holding STEP steps repeatedly.
//
// Ports:
//   clk          system clock; every register updates on its rising edge
//   reset        synchronous, active-high; clears all state and pulses
//   button       raw asynchronous button pins, active-high
//   btn_state    debounced level per channel
//   btn_press    1-cycle pulse on an accepted 0->1 change, plus repeat pulses
//   btn_release  1-cycle pulse on an accepted 1->0 change
//
// Timing (pin stable from before edge 0):
//   btn_state, together with the matching pulse, changes after edge
//   DEBOUNCE_CYCLES+1. This is two synchroniser edges, followed by
//   DEBOUNCE_CYCLES consecutive differing samples, where the last of those
//   samples is the acceptance edge.
// ---------------------------------------------------------------------------
module button_debounce_bank #(
    parameter int                   N_BUTTONS       = 5,
    parameter int                   DEBOUNCE_CYCLES = 500000,
    parameter int                   REPEAT_DELAY    = 50000000,
    parameter int                   REPEAT_PERIOD   = 10000000,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 5'b00100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button,
    output logic [N_BUTTONS-1:0] btn_state,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    // Debounce counter: it only has to count up to DEBOUNCE_CYCLES-1. The
    // acceptance edge then resets it instead of letting it reach
    // DEBOUNCE_CYCLES.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // The hold counter is shared by the initial delay and the repeat period.
    // It is therefore sized for the larger of the two.
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W    = $clog2(REP_MAX + 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    // Auto-repeat phases:
    //   WAIT_DELAY: waiting for the first repeat after the initial press.
    //   REPEATING:  periodic repeats.
    typedef enum logic {
        WAIT_DELAY = 1'b0,
        REPEATING  = 1'b1
    } rep_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
            logic            s1_reg;
            logic            s2_reg;
            logic            state_reg;
            logic            press_reg;
            logic            release_reg;
            logic [DB_W-1:0] db_cnt_reg;
            logic            accept;
            logic            repeat_fire;

            // accept is high on the edge that would take the counter to
            // DEBOUNCE_CYCLES. That edge is the DEBOUNCE_CYCLES-th
            // consecutive sample of s2 that differs from the current level.
            assign accept = (s2_reg != state_reg) && (db_cnt_reg == DB_LAST);

            // Synchroniser, debounce counter and pulse registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg      <= 1'b0;
                    s2_reg      <= 1'b0;
                    state_reg   <= 1'b0;
                    db_cnt_reg  <= '0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    s1_reg <= button[gi];
                    s2_reg <= s1_reg;

                    // A sample that agrees with the current level discards
                    // any partial count, so a short glitch leaves no trace.
                    if (s2_reg == state_reg) begin
                        db_cnt_reg <= '0;
                    end else if (accept) begin
                        db_cnt_reg <= '0;
                        state_reg  <= s2_reg;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end

                    // The pulses are registered on the acceptance edge.
                    // This aligns them with the first cycle of the new level.
                    press_reg   <= (accept && s2_reg) || repeat_fire;
                    release_reg <= accept && !s2_reg;
                end
            end

            if (REPEAT_MASK[gi]) begin : g_rep
                rep_state_t      rep_state_reg;
                logic [RP_W-1:0] hold_cnt_reg;
                logic            hold_done;

                assign hold_done = (rep_state_reg == WAIT_DELAY) ?
                                   (hold_cnt_reg == DELAY_LAST) :
                                   (hold_cnt_reg == PERIOD_LAST);

                // A repeat fires only while the level is held. An accept
                // while state_reg is 1 is a release, and that release
                // suppresses any repeat due on the same edge. This also
                // means press and release can never coincide.
                assign repeat_fire = state_reg && !accept && hold_done;

                // The FSM stays in its cleared state whenever the level is 0.
                // The acceptance edge of a press (or of a release) also
                // leaves it cleared. The first counted edge is therefore the
                // one after the press pulse appears.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        rep_state_reg <= WAIT_DELAY;
                        hold_cnt_reg  <= '0;
                    end else if (!state_reg || accept) begin
                        rep_state_reg <= WAIT_DELAY;
                        hold_cnt_reg  <= '0;
                    end else if (hold_done) begin
                        // Reloading on every repeat keeps the counter from
                        // wrapping, however long the button is held.
                        rep_state_reg <= REPEATING;
                        hold_cnt_reg  <= '0;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_reg + 1'b1;
                    end
                end
            end else begin : g_norep
                assign repeat_fire = 1'b0;
            end

            assign btn_state[gi]   = state_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
        end
    endgenerate

endmodule
